ripple_capture: RTL and testbench

RIPPLE_CAPTURE -- requirements
Module: ripple_capture

---
 rtl/ripple_capture.sv | 203 ++++++++++++++++++++
 tb/tb_ripple_capture.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_capture.sv
// ripple_capture: counts events from an asynchronous 4-bit ripple counter over a fixed
// window of clk cycles. Each window total goes to a single-entry valid/ready output register.
// The raw counter value is synchronized and only accepted once it has settled, so the
// counter's ripple glitches are filtered out.
// Build option: define RIPPLE_CAPTURE_SAT_EN to make the accumulator saturate and to add
// the 'sat' output. Without it the accumulator wraps and 'sat' does not exist.
module ripple_capture #(
   parameter int unsigned WINDOW = 256,
   parameter int unsigned ACC_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       q,
   input  logic             clear,
   output logic [ACC_W-1:0] out_count,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overrun
`ifdef RIPPLE_CAPTURE_SAT_EN
   ,
   output logic             sat
`endif
);

   localparam int unsigned WcntW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [WcntW-1:0] WcntLast = WcntW'(WINDOW - 1);

   typedef enum logic [0:0] {
      StSeed,
      StRun
   } state_e;

   state_e state_q, state_d;

   // Synchronizer and settle detection
   logic [3:0] sync1_q, sync2_q;
   logic [1:0] fill_q;      // marks which sync stages hold real q samples since reset
   logic       stable;
   logic [3:0] delta;

   // Window datapath
   logic [3:0]       last_q;
   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_sum;
   logic [WcntW-1:0] wcnt_q;

   // FSM controls
   logic seed_load;
   logic run_step;
   logic terminal;

   // Output register
   logic [ACC_W-1:0] out_count_q;
   logic             out_valid_q;
   logic             overrun_q;

`ifdef RIPPLE_CAPTURE_SAT_EN
   localparam int unsigned AccWideW = ACC_W + 1;
   logic [ACC_W:0] acc_wide;
   logic           acc_sat_q;
   logic           win_sat;
   logic           sat_q;
`endif

   // Two-flop synchronizer for the asynchronous counter value
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         fill_q  <= '0;
      end else begin
         sync1_q <= q;
         sync2_q <= sync1_q;
         fill_q  <= {fill_q[0], 1'b1};
      end
   end

   // sync2 is stable when it will hold the same value next cycle (sync1 already matches).
   // The reset value of the chain is never treated as a sample.
   always_comb begin
      stable = fill_q[1] && (sync1_q == sync2_q);
      delta  = 4'd0;
      if (stable) begin
         delta = sync2_q - last_q;  // 4-bit subtraction gives the modulo-16 step
      end
   end

   // Accumulator next value: wrapping or saturating
   always_comb begin
`ifdef RIPPLE_CAPTURE_SAT_EN
      acc_wide = {1'b0, acc_q} + AccWideW'(delta);
      win_sat  = acc_sat_q | acc_wide[ACC_W];
      acc_sum  = acc_wide[ACC_W] ? {ACC_W{1'b1}} : acc_wide[ACC_W-1:0];
`else
      acc_sum  = acc_q + ACC_W'(delta);
`endif
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StSeed;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: clear always restarts from a fresh baseline
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = StSeed;
      end else begin
         unique case (state_q)
            StSeed:  if (stable) state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StSeed;
         endcase
      end
   end

   // FSM outputs: datapath strobes, with clear overriding any window activity
   always_comb begin
      seed_load = 1'b0;
      run_step  = 1'b0;
      terminal  = 1'b0;
      if (!clear) begin
         unique case (state_q)
            StSeed: seed_load = stable;
            StRun: begin
               run_step = 1'b1;
               terminal = (wcnt_q == WcntLast);
            end
            default: ;
         endcase
      end
   end

   // Baseline, accumulator and window counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_q <= '0;
         acc_q  <= '0;
         wcnt_q <= '0;
      end else begin
         if (seed_load || (run_step && stable)) begin
            last_q <= sync2_q;
         end
         if (clear || terminal) begin
            acc_q  <= '0;
            wcnt_q <= '0;
         end else if (run_step) begin
            acc_q  <= acc_sum;
            wcnt_q <= wcnt_q + 1'b1;
         end
      end
   end

`ifdef RIPPLE_CAPTURE_SAT_EN
   // Remembers whether the running window has hit the saturation ceiling
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_sat_q <= 1'b0;
      end else if (clear || terminal) begin
         acc_sat_q <= 1'b0;
      end else if (run_step) begin
         acc_sat_q <= win_sat;
      end
   end
`endif

   // Result register with valid/ready handshake and sticky overrun
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_count_q <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef RIPPLE_CAPTURE_SAT_EN
         sat_q       <= 1'b0;
`endif
      end else if (terminal) begin
         // A load on the same edge as an accepted transfer replaces it cleanly
         out_count_q <= acc_sum;
         out_valid_q <= 1'b1;
         if (out_valid_q && !out_ready) begin
            overrun_q <= 1'b1;
         end
`ifdef RIPPLE_CAPTURE_SAT_EN
         sat_q       <= win_sat;
`endif
      end else if (out_valid_q && out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_count = out_count_q;
   assign out_valid = out_valid_q;
   assign overrun   = overrun_q;
`ifdef RIPPLE_CAPTURE_SAT_EN
   assign sat       = sat_q;
`endif

endmodule

// File: tb/tb_ripple_capture.sv
// Bench for ripple_capture: directed scenarios with literal expectations, then random
// stimulus, all continuously compared against a sample-history reference model.
module tb_ripple_capture;

   localparam int unsigned WINDOW = 64;
   localparam int unsigned ACC_W  = 8;
   localparam longint     MAXV   = (longint'(1) << ACC_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [3:0]       q = 4'd5;
   logic             clear = 1'b0;
   logic             out_ready = 1'b0;
   logic [ACC_W-1:0] out_count;
   logic             out_valid;
   logic             overrun;
`ifdef RIPPLE_CAPTURE_SAT_EN
   logic             sat;
`endif

   int n_err = 0;
   int n_checks = 0;

   ripple_capture #(
      .WINDOW(WINDOW),
      .ACC_W (ACC_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .q        (q),
      .clear    (clear),
      .out_count(out_count),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .overrun  (overrun)
`ifdef RIPPLE_CAPTURE_SAT_EN
      ,
      .sat      (sat)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: keeps the q values seen at the last two edges and applies the
   // window rules with plain integer arithmetic (unbounded total, clipped at load time).
   logic [3:0] qh[$];
   bit         m_seeded = 0;
   int         m_last = 0;
   longint     m_acc = 0;
   int         m_wpos = 0;
   longint     m_count = 0;
   bit         m_valid = 0;
   bit         m_over = 0;
   bit         m_sat = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         qh.delete();
         m_seeded = 0; m_last = 0; m_acc = 0; m_wpos = 0;
         m_count = 0; m_valid = 0; m_over = 0; m_sat = 0;
      end else begin
         bit     stb;
         int     s;
         int     d;
         bit     ld;
         longint tot;
         stb = (qh.size() == 2) && (qh[0] == qh[1]);
         s   = stb ? int'(qh[0]) : 0;
         ld  = 0;
         tot = 0;
         if (clear) begin
            m_seeded = 0; m_acc = 0; m_wpos = 0;
         end else if (!m_seeded) begin
            if (stb) begin
               m_last = s;
               m_seeded = 1;
            end
         end else begin
            d = stb ? (s - m_last + 16) % 16 : 0;
            if (stb) m_last = s;
            tot = m_acc + d;
            if (m_wpos == int'(WINDOW) - 1) begin
               ld = 1; m_acc = 0; m_wpos = 0;
            end else begin
               m_acc = tot; m_wpos++;
            end
         end
         if (ld) begin
            if (m_valid && !out_ready) m_over = 1;
`ifdef RIPPLE_CAPTURE_SAT_EN
            m_count = (tot > MAXV) ? MAXV : tot;
            m_sat   = (tot > MAXV);
`else
            m_count = tot % (MAXV + 1);
`endif
            m_valid = 1;
         end else if (m_valid && out_ready) begin
            m_valid = 0;
         end
         qh.push_back(q);
         if (qh.size() > 2) void'(qh.pop_front());
      end
   end

   // Continuous comparison, away from the active edge
   always @(negedge clk) begin
      check("model_out_valid", 32'(out_valid), 32'(m_valid));
      check("model_out_count", 32'(out_count), 32'(m_count));
      check("model_overrun", 32'(overrun), 32'(m_over));
`ifdef RIPPLE_CAPTURE_SAT_EN
      check("model_sat", 32'(sat), 32'(m_sat));
`endif
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic [3:0] v, input int n);
      q = v;
      repeat (n) tick();
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      do begin
         tick();
         n++;
      end while (out_valid && n < 200);
      check("drain_valid_clears", 32'(out_valid), 32'd0);
      out_ready = 1'b0;
   endtask

   // Settle q at v, empty the output register, then restart the window on v
   task automatic start_window(input logic [3:0] v);
      q = v;
      repeat (4) tick();
      drain();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic wait_result(input string name, input int exp);
      int n;
      n = 0;
      while (!out_valid && n < 200) begin
         tick();
         n++;
      end
      check({name, "_valid"}, 32'(out_valid), 32'd1);
      check(name, 32'(out_count), 32'(exp));
   endtask

   initial begin
      logic [3:0] v;
      #1 reset = 1'b0;
      out_ready = 1'b0;
      q = 4'd5;
      repeat (3) tick();
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_count", 32'(out_count), 32'd0);
      check("reset_overrun", 32'(overrun), 32'd0);
      reset = 1'b1;

      // Baseline 5 held: first window has no events
      wait_result("seed_first", 0);

      // Steps 0..9, each held 3 cycles
      start_window(4'd0);
      for (int i = 1; i <= 9; i++) hold(4'(i), 3);
      wait_result("steps", 9);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("handshake_clears", 32'(out_valid), 32'd0);

      // One-cycle glitch 3 -> 7 -> 4
      start_window(4'd3);
      hold(4'd3, 3);
      hold(4'd7, 1);
      hold(4'd4, 3);
      wait_result("glitch", 1);

      // 300 events in one window: 20 steps of +15, each held 2 cycles
      start_window(4'd0);
      hold(4'd0, 2);
      v = 4'd0;
      for (int i = 0; i < 20; i++) begin
         v = v + 4'd15;
         hold(v, 2);
      end
`ifdef RIPPLE_CAPTURE_SAT_EN
      wait_result("sat_count", 255);
      check("sat_flag", 32'(sat), 32'd1);
`else
      wait_result("wrap_count", 44);
`endif

      // Upstream wrap 13,14,15,0,1,2
      start_window(4'd13);
      hold(4'd13, 4); hold(4'd14, 4); hold(4'd15, 4);
      hold(4'd0, 4);  hold(4'd1, 4);  hold(4'd2, 4);
      wait_result("upstream_wrap", 5);

      // Next window +4, consumed on the very edge it loads
      q = 4'd6;
      repeat (WINDOW - 1) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("load_on_accept_valid", 32'(out_valid), 32'd1);
      check("load_on_accept_count", 32'(out_count), 32'd4);
      check("load_on_accept_overrun", 32'(overrun), 32'd0);

      // Next window +3 with nobody consuming: overwrite and overrun
      q = 4'd9;
      repeat (WINDOW) tick();
      check("overrun_flag", 32'(overrun), 32'd1);
      check("overrun_count", 32'(out_count), 32'd3);

      // Reset mid-window clears everything
      hold(4'd12, 10);
      reset = 1'b0;
      tick();
      check("midreset_valid", 32'(out_valid), 32'd0);
      check("midreset_overrun", 32'(overrun), 32'd0);
      check("midreset_count", 32'(out_count), 32'd0);
      reset = 1'b1;

      // Random phase
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(2) == 0) q = 4'($urandom_range(15));
         out_ready = ((i / 500) % 2 == 1) ? 1'($urandom_range(1)) : 1'b0;
         clear = ($urandom_range(299) == 0);
         if (i == 2100) reset = 1'b0;
         if (i == 2103) reset = 1'b1;
         tick();
      end
      clear = 1'b0;
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
